sd_blk_rd_rcvr: RTL and testbench

SD_BLK_RD_RCVR -- requirements
Module: sd_blk_rd_rcvr

---
 rtl/sd_blk_rd_rcvr.sv | 134 +++++++++++++
 tb/tb_sd_blk_rd_rcvr.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_blk_rd_rcvr.sv
// SD card single-block read receiver for DAT0 in 1-bit bus mode.
// Detects the start bit, deserialises bytes MSB-first, checks CRC16 and the end bit.
module sd_blk_rd_rcvr #(
    parameter int          BLK_BYTES = 512,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sd_clk_en,
    input  logic       start,
    input  logic       dat0,
    output logic [7:0] rd_byte,
    output logic       rd_byte_vld,
    output logic       blk_done,
    output logic       crc_err,
    output logic       end_err,
    output logic       timeout_err,
    output logic       busy
);

    localparam int             BCW       = $clog2(BLK_BYTES + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BLK_BYTES - 1);

    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END_BIT, DONE} state_t;

    state_t         state;
    logic [2:0]     bit_cnt;
    logic [BCW-1:0] byte_cnt;
    logic [15:0]    tmo_cnt;
    logic [3:0]     crc_cnt;
    logic [15:0]    crc;
    logic [15:0]    rx_crc;
    logic [6:0]     shreg;

    // One serial step of CRC16-CCITT (x^16 + x^12 + x^5 + 1).
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
            crc_cnt     <= '0;
            crc         <= '0;
            rx_crc      <= '0;
            shreg       <= '0;
            rd_byte     <= 8'h00;
            rd_byte_vld <= 1'b0;
            blk_done    <= 1'b0;
            crc_err     <= 1'b0;
            end_err     <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rd_byte_vld <= 1'b0;
            blk_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt     <= '0;
                        byte_cnt    <= '0;
                        tmo_cnt     <= '0;
                        crc_cnt     <= '0;
                        crc         <= '0;
                        rx_crc      <= '0;
                        crc_err     <= 1'b0;
                        end_err     <= 1'b0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        state       <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (sd_clk_en) begin
                        if (!dat0) begin
                            state <= DATA;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                            if (tmo_cnt + 16'd1 == TIMEOUT) begin
                                timeout_err <= 1'b1;
                                blk_done    <= 1'b1;
                                state       <= DONE;
                            end
                        end
                    end
                end
                DATA: begin
                    if (sd_clk_en) begin
                        shreg   <= {shreg[5:0], dat0};
                        crc     <= crc16_step(crc, dat0);
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rd_byte     <= {shreg, dat0};
                            rd_byte_vld <= 1'b1;
                            byte_cnt    <= byte_cnt + BCW'(1);
                            if (byte_cnt == LAST_BYTE)
                                state <= CRC;
                        end
                    end
                end
                CRC: begin
                    if (sd_clk_en) begin
                        rx_crc  <= {rx_crc[14:0], dat0};
                        crc_cnt <= crc_cnt + 4'd1;
                        if (crc_cnt == 4'd15)
                            state <= END_BIT;
                    end
                end
                END_BIT: begin
                    if (sd_clk_en) begin
                        if (!dat0)
                            end_err <= 1'b1;
                        if (rx_crc != crc)
                            crc_err <= 1'b1;
                        blk_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // blk_done was raised on entry; leave after exactly one clk.
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_blk_rd_rcvr.sv
// Scoreboard bench for sd_blk_rd_rcvr: a 512-byte instance and a 4-byte instance
// share DAT0 and the sample strobe; each has its own start.
module tb_sd_blk_rd_rcvr;

    logic clk = 1'b0;
    logic reset;
    logic sd_clk_en;
    logic dat0;
    logic start_a, start_b;

    logic [7:0] rd_byte_a, rd_byte_b;
    logic       rd_byte_vld_a, rd_byte_vld_b;
    logic       blk_done_a, blk_done_b;
    logic       crc_err_a, crc_err_b;
    logic       end_err_a, end_err_b;
    logic       timeout_err_a, timeout_err_b;
    logic       busy_a, busy_b;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    bit   sel_b = 1'b0;
    int   done_a = 0, done_b = 0;
    logic [2:0] flags_a = '0, flags_b = '0;

    sd_blk_rd_rcvr #(.BLK_BYTES(512), .TIMEOUT(16'd16)) dut_a (
        .clk(clk), .reset(reset), .sd_clk_en(sd_clk_en), .start(start_a), .dat0(dat0),
        .rd_byte(rd_byte_a), .rd_byte_vld(rd_byte_vld_a), .blk_done(blk_done_a),
        .crc_err(crc_err_a), .end_err(end_err_a), .timeout_err(timeout_err_a), .busy(busy_a)
    );

    sd_blk_rd_rcvr #(.BLK_BYTES(4), .TIMEOUT(16'd16)) dut_b (
        .clk(clk), .reset(reset), .sd_clk_en(sd_clk_en), .start(start_b), .dat0(dat0),
        .rd_byte(rd_byte_b), .rd_byte_vld(rd_byte_vld_b), .blk_done(blk_done_b),
        .crc_err(crc_err_b), .end_err(end_err_b), .timeout_err(timeout_err_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    // Monitor: pops the scoreboard on every byte strobe, records block completions.
    always @(negedge clk) begin
        if (rd_byte_vld_a || rd_byte_vld_b) begin
            tests++;
            if ((rd_byte_vld_a && sel_b) || (rd_byte_vld_b && !sel_b)) begin
                fails++;
                $display("FAIL stray_vld: got vld_a=%0b vld_b=%0b sel_b=%0b", rd_byte_vld_a, rd_byte_vld_b, sel_b);
            end else if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_byte: got %0h expected none", sel_b ? rd_byte_b : rd_byte_a);
            end else begin
                logic [7:0] e;
                logic [7:0] g;
                e = exp_q.pop_front();
                g = sel_b ? rd_byte_b : rd_byte_a;
                if (g !== e) begin
                    fails++;
                    $display("FAIL rd_byte: got %0h expected %0h", g, e);
                end
            end
        end
        if (blk_done_a) begin
            done_a++;
            flags_a = {crc_err_a, end_err_a, timeout_err_a};
        end
        if (blk_done_b) begin
            done_b++;
            flags_b = {crc_err_b, end_err_b, timeout_err_b};
        end
    end

    task automatic send_bit(input logic b);
        dat0      = b;
        sd_clk_en = 1'b1;
        @(negedge clk);
        sd_clk_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start(input bit b);
        @(negedge clk);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Sends idle 1s, start bit, n bytes, CRC and end bit. A stall byte holds the strobe
    // low for 50 clks mid-byte while pulsing start; an abort byte drops reset mid-byte.
    task automatic send_block(input int n, input bit all_ff, input bit flip, input logic endb,
                              input int stall_byte, input int abort_byte);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'h0000;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) begin
            b = all_ff ? 8'hFF : 8'(i);
            if (i != abort_byte) exp_q.push_back(b);
            c = crc_byte(c, b);
            for (int j = 0; j < 8; j++) begin
                if (j == 4 && i == abort_byte) begin
                    reset = 1'b0;
                    return;
                end
                if (j == 4 && i == stall_byte) begin
                    for (int s = 0; s < 50; s++) begin
                        start_a = (s == 10 || s == 30);
                        @(negedge clk);
                    end
                    start_a = 1'b0;
                end
                send_bit(b[7-j]);
            end
        end
        if (flip) c[0] = ~c[0];
        for (int k = 15; k >= 0; k--) send_bit(c[k]);
        send_bit(endb);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int d0;
        reset = 1'b0; sd_clk_en = 1'b0; dat0 = 1'b1; start_a = 1'b0; start_b = 1'b0;
        #2;
        check("reset_outputs", {rd_byte_a, rd_byte_vld_a, blk_done_a, crc_err_a, end_err_a, timeout_err_a, busy_a}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Good 512-byte block.
        pulse_start(1'b0);
        check("busy_after_start", busy_a, 1);
        d0 = done_a;
        send_block(512, 1'b0, 1'b0, 1'b1, -1, -1);
        check("good_done_cnt", done_a - d0, 1);
        check("good_flags", flags_a, 3'b000);
        check("good_all_bytes", exp_q.size(), 0);
        check("good_busy_low", busy_a, 0);

        // Last CRC bit inverted.
        pulse_start(1'b0);
        d0 = done_a;
        send_block(512, 1'b0, 1'b1, 1'b1, -1, -1);
        check("crcbad_done_cnt", done_a - d0, 1);
        check("crcbad_flags", flags_a, 3'b100);
        check("crcbad_all_bytes", exp_q.size(), 0);
        check("crcbad_sticky", crc_err_a, 1);

        // Timeout: dat0 held high for 16 samples.
        pulse_start(1'b0);
        d0 = done_a;
        for (int i = 0; i < 15; i++) send_bit(1'b1);
        check("tmo_not_yet", {blk_done_a, timeout_err_a, busy_a}, 3'b001);
        dat0 = 1'b1;
        sd_clk_en = 1'b1;
        @(negedge clk);
        sd_clk_en = 1'b0;
        check("tmo_done_pulse", {blk_done_a, timeout_err_a}, 2'b11);
        repeat (3) @(negedge clk);
        check("tmo_done_cnt", done_a - d0, 1);
        check("tmo_flags", flags_a, 3'b001);
        check("tmo_busy_low", busy_a, 0);
        check("tmo_sticky", timeout_err_a, 1);

        // Reset in the middle of byte 100.
        pulse_start(1'b0);
        d0 = done_a;
        send_block(512, 1'b0, 1'b0, 1'b1, -1, 100);
        #1;
        check("abort_outputs", {rd_byte_a, rd_byte_vld_a, blk_done_a, crc_err_a, end_err_a, timeout_err_a, busy_a}, 32'h0);
        check("abort_bytes", exp_q.size(), 0);
        repeat (10) @(negedge clk);
        check("abort_no_done", done_a - d0, 0);
        reset = 1'b1;
        dat0 = 1'b1;

        // Good block with ignored starts and a 50-clk strobe gap mid-byte.
        pulse_start(1'b0);
        d0 = done_a;
        send_block(512, 1'b0, 1'b0, 1'b1, 200, -1);
        check("stall_done_cnt", done_a - d0, 1);
        check("stall_flags", flags_a, 3'b000);
        check("stall_all_bytes", exp_q.size(), 0);

        // 4-byte instance: all-0xFF with bad end bit, then a good block.
        sel_b = 1'b1;
        pulse_start(1'b1);
        d0 = done_b;
        send_block(4, 1'b1, 1'b0, 1'b0, -1, -1);
        check("endbad_done_cnt", done_b - d0, 1);
        check("endbad_flags", flags_b, 3'b010);
        check("endbad_sticky", end_err_b, 1);
        pulse_start(1'b1);
        check("endbad_restart_busy", busy_b, 1);
        check("endbad_cleared", end_err_b, 0);
        d0 = done_b;
        send_block(4, 1'b0, 1'b0, 1'b1, -1, -1);
        check("good4_done_cnt", done_b - d0, 1);
        check("good4_flags", flags_b, 3'b000);
        check("good4_all_bytes", exp_q.size(), 0);
        check("a_stays_idle", busy_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
